// File: rtl/bios_boot_scheduler_pkg.sv
// Shared types and constants for the BIOS boot scheduler: state encodings,
// StatusReg bit layout and parameter defaults.
package bios_boot_scheduler_pkg;

   localparam int unsigned MAX_ATTEMPTS_DEF = 4;
   localparam int unsigned OFF_HOLD_DEF     = 32;
   localparam int unsigned ON_DELAY_DEF     = 8;

   localparam int unsigned CNT_W    = 3;
   localparam int unsigned STATE_W  = 3;
   localparam int unsigned STRB_W   = 6;
   localparam int unsigned STATUS_W = 8;

   // StatusReg = {BootFault, BiosSel, AttemptCnt[2:0], BootState[2:0]}
   localparam int unsigned STS_FAULT     = 7;
   localparam int unsigned STS_SEL       = 6;
   localparam int unsigned STS_CNT_LSB   = 3;
   localparam int unsigned STS_STATE_LSB = 0;

   typedef enum logic [STATE_W-1:0] {
      ST_OFF     = 3'd0,
      ST_BOOT    = 3'd1,
      ST_DONE    = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RESTART = 3'd4,
      ST_FAULT   = 3'd5
   } boot_state_e;

endpackage

// File: rtl/bios_boot_scheduler_if.sv
// Platform-side signal bundle of the boot scheduler; master drives the
// platform inputs, slave is the scheduler itself.
interface bios_boot_scheduler_if;
   import bios_boot_scheduler_pkg::*;

   logic                Strobe125msec;
   logic                PS_ONn;
   logic                BiosFinished;
   logic                BiosPowerOff;
   logic                DefaultBios;
   logic                SwapAllowed;
   logic                ClearFault;
   logic                BiosSel;
   logic                ForcePowerOff;
   logic                PowerOnReq;
   logic [CNT_W-1:0]    AttemptCnt;
   logic [STATE_W-1:0]  BootState;
   logic                BootFault;
   logic [STATUS_W-1:0] StatusReg;

   modport master (
      output Strobe125msec, PS_ONn, BiosFinished, BiosPowerOff,
             DefaultBios, SwapAllowed, ClearFault,
      input  BiosSel, ForcePowerOff, PowerOnReq, AttemptCnt,
             BootState, BootFault, StatusReg
   );

   modport slave (
      input  Strobe125msec, PS_ONn, BiosFinished, BiosPowerOff,
             DefaultBios, SwapAllowed, ClearFault,
      output BiosSel, ForcePowerOff, PowerOnReq, AttemptCnt,
             BootState, BootFault, StatusReg
   );

endinterface

// File: rtl/bios_boot_scheduler_wd_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector; turns an
// asynchronous level into a single-cycle pulse in the local clock domain.
module wd_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse_c
);

   logic [2:0] sync;

   always_ff @(posedge clk) begin
      if (rst) sync <= 3'b000;
      else     sync <= {sync[1:0], din};
   end

   // sync[2] is only the edge-detect history, not a third metastability stage
   assign pulse_c = sync[1] & ~sync[2];

endmodule

// File: rtl/bios_boot_scheduler.sv
// BIOS boot attempt sequencer: counts watchdog-detected boot failures, forces
// power-off/restart cycles, optionally swaps flash and locks out on repeats.
module bios_boot_scheduler
   import bios_boot_scheduler_pkg::*;
#(
   parameter int unsigned MAX_ATTEMPTS = MAX_ATTEMPTS_DEF,
   parameter int unsigned OFF_HOLD     = OFF_HOLD_DEF,
   parameter int unsigned ON_DELAY     = ON_DELAY_DEF
) (
   input logic                 LpcClock,
   input logic                 Reset,
   bios_boot_scheduler_if.slave bus
);

   boot_state_e         state, state_nx;
   logic [CNT_W-1:0]    attempt, attempt_nx;
   logic                sel, sel_nx;
   logic                por_nx;
   logic [STRB_W-1:0]   strb;
   logic                force_off, por, fault;
   logic                wd_fire_c;
   logic [STATUS_W-1:0] status_c;

   wd_edge_sync u_wd_edge_sync (
      .clk     (LpcClock),
      .rst     (Reset),
      .din     (bus.BiosPowerOff),
      .pulse_c (wd_fire_c)
   );

   // Next-state, attempt counter and flash-select decisions
   always_comb begin
      state_nx   = state;
      attempt_nx = attempt;
      sel_nx     = sel;
      por_nx     = 1'b0;
      case (state)
         ST_OFF: if (!bus.PS_ONn) state_nx = ST_BOOT;
         ST_BOOT: begin
            if (bus.BiosFinished) begin
               state_nx = ST_DONE;
            end else if (wd_fire_c) begin
               state_nx   = ST_HOLD;
               attempt_nx = (attempt == '1) ? attempt : attempt + CNT_W'(1);
               if (bus.SwapAllowed) sel_nx = ~sel;
            end else if (bus.PS_ONn) begin
               state_nx = ST_OFF;
            end
         end
         ST_DONE: if (bus.PS_ONn) state_nx = ST_OFF;
         ST_HOLD: begin
            if ((strb >= STRB_W'(OFF_HOLD)) && bus.PS_ONn)
               state_nx = (attempt >= CNT_W'(MAX_ATTEMPTS)) ? ST_FAULT : ST_RESTART;
         end
         ST_RESTART: begin
            if (strb >= STRB_W'(ON_DELAY)) begin
               state_nx = ST_OFF;
               por_nx   = 1'b1;
            end
         end
         ST_FAULT: begin
            if (bus.ClearFault) begin
               state_nx   = ST_OFF;
               attempt_nx = '0;
               sel_nx     = bus.DefaultBios;
            end
         end
         default: state_nx = ST_OFF;
      endcase
      // A successful boot wipes the failure history
      if ((state_nx == ST_DONE) && (state != ST_DONE)) attempt_nx = '0;
   end

   always_ff @(posedge LpcClock) begin
      if (Reset) begin
         state     <= ST_OFF;
         attempt   <= '0;
         sel       <= bus.DefaultBios;
         strb      <= '0;
         force_off <= 1'b0;
         por       <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nx;
         attempt   <= attempt_nx;
         sel       <= sel_nx;
         por       <= por_nx;
         force_off <= (state_nx == ST_HOLD) || (state_nx == ST_FAULT);
         fault     <= (state_nx == ST_FAULT);
         if (state_nx != state)
            strb <= '0;
         else if (bus.Strobe125msec && (strb != '1) &&
                  ((state == ST_HOLD) || (state == ST_RESTART)))
            strb <= strb + STRB_W'(1);
      end
   end

   always_comb begin
      status_c = '0;
      status_c[STS_FAULT]                   = fault;
      status_c[STS_SEL]                     = sel;
      status_c[STS_CNT_LSB +: CNT_W]        = attempt;
      status_c[STS_STATE_LSB +: STATE_W]    = state;
   end

   assign bus.BiosSel       = sel;
   assign bus.ForcePowerOff = force_off;
   assign bus.PowerOnReq    = por;
   assign bus.AttemptCnt    = attempt;
   assign bus.BootState     = state;
   assign bus.BootFault     = fault;
   assign bus.StatusReg     = status_c;

endmodule

// File: tb/tb_bios_boot_scheduler.sv
// Self-checking bench for bios_boot_scheduler: directed plan steps plus a
// randomized boot/fail/power-off mix against an event-level model.
module tb_bios_boot_scheduler;
   import bios_boot_scheduler_pkg::*;

   localparam int unsigned MAXA  = MAX_ATTEMPTS_DEF;
   localparam int unsigned HOLDN = OFF_HOLD_DEF;
   localparam int unsigned ONN   = ON_DELAY_DEF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bios_boot_scheduler_if bus ();

   bios_boot_scheduler dut (
      .LpcClock (clk),
      .Reset    (rst),
      .bus      (bus)
   );

   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;
   int   m_fails;
   logic m_sel;
   logic m_def;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) begin
         if (i > 0) tick($urandom_range(0, 3));
         bus.Strobe125msec = 1'b1;
         tick();
         bus.Strobe125msec = 1'b0;
      end
   endtask

   task automatic do_reset(input logic def);
      rst               = 1'b1;
      bus.DefaultBios   = def;
      bus.PS_ONn        = 1'b1;
      bus.BiosFinished  = 1'b0;
      bus.BiosPowerOff  = 1'b0;
      bus.SwapAllowed   = 1'b0;
      bus.ClearFault    = 1'b0;
      bus.Strobe125msec = 1'b0;
      tick(2);
      rst     = 1'b0;
      m_fails = 0;
      m_sel   = def;
      m_def   = def;
      chk("rst_state", 8'(bus.BootState), 8'd0);
      chk("rst_sel", 8'(bus.BiosSel), 8'(def));
      chk("rst_cnt", 8'(bus.AttemptCnt), 8'd0);
   endtask

   task automatic boot_up();
      bus.PS_ONn = 1'b0;
      tick();
      chk("boot_entry", 8'(bus.BootState), 8'd1);
   endtask

   task automatic clear_fault();
      bus.ClearFault = 1'b1;
      tick();
      bus.ClearFault = 1'b0;
      m_fails = 0;
      m_sel   = m_def;
      chk("clr_state", 8'(bus.BootState), 8'd0);
      chk("clr_cnt", 8'(bus.AttemptCnt), 8'd0);
      chk("clr_fault", 8'(bus.BootFault), 8'd0);
      chk("clr_sel", 8'(bus.BiosSel), 8'(m_sel));
   endtask

   // One failed boot from BOOT onward; hold_extra > 0 keeps PS_ONn low past the hold time
   task automatic run_fail(input logic swap, input int hold_extra);
      logic [7:0] exp_status;
      bus.SwapAllowed  = swap;
      bus.BiosPowerOff = 1'b1;
      tick(2);
      chk("wd_latency", 8'(bus.BootState), 8'd1);
      tick();
      m_fails = (m_fails < 7) ? m_fails + 1 : 7;
      if (swap) m_sel = ~m_sel;
      chk("hold_entry", 8'(bus.BootState), 8'd3);
      chk("hold_cnt", 8'(bus.AttemptCnt), 8'(m_fails));
      chk("hold_sel", 8'(bus.BiosSel), 8'(m_sel));
      chk("hold_fpo", 8'(bus.ForcePowerOff), 8'd1);
      bus.BiosPowerOff = 1'b0;
      if (hold_extra > 0) begin
         strobes(HOLDN + hold_extra);
         tick();
         chk("held_state", 8'(bus.BootState), 8'd3);
         chk("held_fpo", 8'(bus.ForcePowerOff), 8'd1);
         bus.PS_ONn = 1'b1;
         tick();
      end else begin
         bus.PS_ONn = 1'b1;
         strobes(HOLDN - 1);
         chk("hold_early", 8'(bus.BootState), 8'd3);
         chk("hold_early_fpo", 8'(bus.ForcePowerOff), 8'd1);
         strobes(1);
         tick();
      end
      if (m_fails >= MAXA) begin
         exp_status = {1'b1, m_sel, 3'(m_fails), 3'd5};
         chk("fault_state", 8'(bus.BootState), 8'd5);
         chk("fault_flag", 8'(bus.BootFault), 8'd1);
         chk("fault_fpo", 8'(bus.ForcePowerOff), 8'd1);
         chk("fault_status", bus.StatusReg, exp_status);
      end else begin
         chk("restart_state", 8'(bus.BootState), 8'd4);
         chk("restart_fpo", 8'(bus.ForcePowerOff), 8'd0);
         strobes(ONN - 1);
         chk("restart_wait", 8'(bus.BootState), 8'd4);
         chk("restart_por0", 8'(bus.PowerOnReq), 8'd0);
         strobes(1);
         tick();
         chk("por_state", 8'(bus.BootState), 8'd0);
         chk("por_pulse", 8'(bus.PowerOnReq), 8'd1);
         tick();
         chk("por_single", 8'(bus.PowerOnReq), 8'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic def;
      do_reset(1'b0);
      chk("rst_fpo", 8'(bus.ForcePowerOff), 8'd0);
      chk("rst_por", 8'(bus.PowerOnReq), 8'd0);
      chk("rst_fault", 8'(bus.BootFault), 8'd0);

      // Normal boot
      boot_up();
      bus.BiosFinished = 1'b1;
      tick();
      chk("t1_done", 8'(bus.BootState), 8'd2);
      chk("t1_cnt", 8'(bus.AttemptCnt), 8'd0);
      chk("t1_fpo", 8'(bus.ForcePowerOff), 8'd0);
      chk("t1_por", 8'(bus.PowerOnReq), 8'd0);
      bus.BiosFinished = 1'b0;
      bus.PS_ONn       = 1'b1;
      tick();
      chk("t1_off", 8'(bus.BootState), 8'd0);

      // Single failure with swap
      do_reset(1'b0);
      boot_up();
      run_fail(1'b1, 0);

      // Lockout
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) begin
         boot_up();
         run_fail(1'b0, 0);
      end
      chk("t3_status", bus.StatusReg, 8'b1010_0101);
      bus.PS_ONn = 1'b0;
      tick(3);
      chk("t3_pson_ignored", 8'(bus.BootState), 8'd5);
      bus.PS_ONn = 1'b1;
      clear_fault();

      // Finish and watchdog fire together
      do_reset(1'b0);
      bus.SwapAllowed = 1'b1;
      boot_up();
      bus.BiosPowerOff = 1'b1;
      tick(2);
      bus.BiosFinished = 1'b1;
      tick();
      chk("t4_state", 8'(bus.BootState), 8'd2);
      chk("t4_cnt", 8'(bus.AttemptCnt), 8'd0);
      chk("t4_sel", 8'(bus.BiosSel), 8'd0);
      bus.BiosPowerOff = 1'b0;
      bus.BiosFinished = 1'b0;
      bus.PS_ONn       = 1'b1;
      tick();
      chk("t4_off", 8'(bus.BootState), 8'd0);

      // Power held on through the hold time
      do_reset(1'b1);
      boot_up();
      run_fail(1'b1, 8);

      // Reset mid-HOLD, then a stray clear in OFF
      def = 1'($urandom_range(0, 1));
      do_reset(def);
      boot_up();
      bus.SwapAllowed  = 1'b1;
      bus.BiosPowerOff = 1'b1;
      tick(3);
      chk("t6_hold", 8'(bus.BootState), 8'd3);
      bus.BiosPowerOff = 1'b0;
      bus.PS_ONn       = 1'b1;
      strobes(10);
      rst = 1'b1;
      tick();
      chk("t6_state", 8'(bus.BootState), 8'd0);
      chk("t6_fpo", 8'(bus.ForcePowerOff), 8'd0);
      chk("t6_sel", 8'(bus.BiosSel), 8'(def));
      chk("t6_cnt", 8'(bus.AttemptCnt), 8'd0);
      rst = 1'b0;
      bus.ClearFault = 1'b1;
      tick();
      bus.ClearFault = 1'b0;
      chk("t6_stray_state", 8'(bus.BootState), 8'd0);
      chk("t6_stray_fault", 8'(bus.BootFault), 8'd0);

      // Randomized mix of boots, failures and aborted boots
      do_reset(1'($urandom_range(0, 1)));
      for (int it = 0; it < 10; it++) begin
         boot_up();
         case ($urandom_range(0, 2))
            0: begin
               bus.BiosFinished = 1'b1;
               tick();
               m_fails = 0;
               chk("r_done", 8'(bus.BootState), 8'd2);
               chk("r_done_cnt", 8'(bus.AttemptCnt), 8'd0);
               bus.BiosFinished = 1'b0;
               bus.PS_ONn       = 1'b1;
               tick();
               chk("r_done_off", 8'(bus.BootState), 8'd0);
            end
            1: begin
               bus.PS_ONn = 1'b1;
               tick();
               chk("r_abort", 8'(bus.BootState), 8'd0);
               chk("r_abort_cnt", 8'(bus.AttemptCnt), 8'(m_fails));
               chk("r_abort_sel", 8'(bus.BiosSel), 8'(m_sel));
            end
            default: begin
               run_fail(1'($urandom_range(0, 1)),
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0);
               if (m_fails >= MAXA) clear_fault();
            end
         endcase
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
